// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - BHT of saturating counters with optional gshare indexing (BHT_GSHARE_EN)
module branch_predictor_bht #(
    parameter int ENTRIES  = 64,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 1,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pred_pc,
    input  logic [6:0]       pred_opcode,
    output logic             pred_branch,
    output logic             pred_taken,
    output logic [CTR_W-1:0] pred_ctr,
    output logic [IDX_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic             upd_pred,
    input  logic [IDX_W-1:0] upd_ghr,
    output logic             upd_mispredict,
    output logic [31:0]      mispred_cnt
);

    localparam logic [6:0]       OPC_BRANCH = 7'b1100011;
    localparam logic [CTR_W-1:0] CTR_RESET  = CTR_W'(INIT_CTR);

    logic [CTR_W-1:0] ctr_table [ENTRIES];
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;
    logic [CTR_W-1:0] lookup_val;

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Global history shifts in every resolved outcome; oldest bit falls off the top
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (upd_valid) begin
            ghr <= (ghr << 1) | IDX_W'(upd_taken);
        end
    end

    assign lookup_idx = pred_pc[IDX_W+1:2] ^ ghr;
    assign update_idx = upd_pc[IDX_W+1:2] ^ upd_ghr;
    assign pred_ghr   = ghr;
`else
    logic unused_upd_ghr;

    assign unused_upd_ghr = ^upd_ghr;
    assign lookup_idx     = pred_pc[IDX_W+1:2];
    assign update_idx     = upd_pc[IDX_W+1:2];
    assign pred_ghr       = '0;
`endif

    // Only the word-index bits of the PCs select an entry
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

    // Lookup reads the array as it stands this cycle; a same-cycle update shows up next cycle
    always_comb begin
        lookup_val     = ctr_table[lookup_idx];
        pred_branch    = (pred_opcode == OPC_BRANCH);
        pred_ctr       = pred_branch ? lookup_val : '0;
        pred_taken     = pred_branch & lookup_val[CTR_W-1];
        upd_mispredict = upd_valid & (upd_pred != upd_taken);
    end

    // Saturating counter update of the resolved entry; reset restores every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_table[i] <= CTR_RESET;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                if (ctr_table[update_idx] != '1) begin
                    ctr_table[update_idx] <= ctr_table[update_idx] + 1'b1;
                end
            end else begin
                if (ctr_table[update_idx] != '0) begin
                    ctr_table[update_idx] <= ctr_table[update_idx] - 1'b1;
                end
            end
        end
    end

    // Mispredict statistics, held at all-ones once full
    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_cnt <= '0;
        end else if (upd_mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
            mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - randomized model-checked bench for branch_predictor_bht
module tb_branch_predictor_bht;

    localparam int ENTRIES = 64;
    localparam int CTR_W   = 2;
    localparam int IDX_W   = 6;
    localparam int CTR_MAX = (1 << CTR_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      pred_pc;
    logic [6:0]       pred_opcode;
    logic             pred_branch;
    logic             pred_taken;
    logic [CTR_W-1:0] pred_ctr;
    logic [IDX_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic             upd_pred;
    logic [IDX_W-1:0] upd_ghr;
    logic             upd_mispredict;
    logic [31:0]      mispred_cnt;

    branch_predictor_bht dut (
        .clk(clk), .rst(rst),
        .pred_pc(pred_pc), .pred_opcode(pred_opcode),
        .pred_branch(pred_branch), .pred_taken(pred_taken),
        .pred_ctr(pred_ctr), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_pred(upd_pred), .upd_ghr(upd_ghr),
        .upd_mispredict(upd_mispredict), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    int unsigned m_ctr [ENTRIES];
    int unsigned m_ghr;
    longint unsigned m_cnt;

    logic [31:0] obs_ctr, obs_taken, obs_branch, obs_mis, obs_cnt, obs_ghr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
        m_ghr = 0;
        m_cnt = 0;
    endtask

    function automatic int unsigned gsh(input int unsigned g);
`ifdef BHT_GSHARE_EN
        return g;
`else
        return 0;
`endif
    endfunction

    // One cycle: drive, compare against the model before the edge, advance the model after it
    task automatic step(input logic r, input logic [31:0] ppc, input logic [6:0] op,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic up, input logic [IDX_W-1:0] ug);
        int unsigned pi, ui, e_ctr;
        logic e_br, e_mis;
        @(negedge clk);
        rst = r; pred_pc = ppc; pred_opcode = op;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_pred = up; upd_ghr = ug;
        #1;
        pi    = ((ppc / 4) % ENTRIES) ^ gsh(m_ghr);
        e_br  = (op == 7'h63);
        e_ctr = e_br ? m_ctr[pi] : 0;
        e_mis = uv && (up != ut);
        obs_ctr = 32'(pred_ctr); obs_taken = 32'(pred_taken); obs_branch = 32'(pred_branch);
        obs_mis = 32'(upd_mispredict); obs_cnt = mispred_cnt; obs_ghr = 32'(pred_ghr);
        chk("pred_branch", obs_branch, 32'(e_br));
        chk("pred_ctr", obs_ctr, e_ctr);
        chk("pred_taken", obs_taken, 32'(e_br && (m_ctr[pi] > CTR_MAX / 2)));
        chk("pred_ghr", obs_ghr, gsh(m_ghr));
        chk("upd_mispredict", obs_mis, 32'(e_mis));
        chk("mispred_cnt", obs_cnt, 32'(m_cnt));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (e_mis && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (uv) begin
                ui = ((upc / 4) % ENTRIES) ^ gsh(32'(ug));
                if (ut) m_ctr[ui] = (m_ctr[ui] == CTR_MAX) ? CTR_MAX : m_ctr[ui] + 1;
                else    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                m_ghr = ((m_ghr << 1) | 32'(ut)) % ENTRIES;
            end
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic [6:0] op);
        step(1'b0, pc, op, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    endtask

    task automatic upd(input logic [31:0] ppc, input logic [31:0] upc, input logic ut, input logic up);
        step(1'b0, ppc, 7'h63, 1'b1, upc, ut, up, IDX_W'(gsh(m_ghr)));
    endtask

    task automatic do_reset();
        step(1'b1, 32'h0, 7'h0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    endtask

    int t2_exp [7] = '{1, 2, 3, 3, 2, 1, 0};

    initial begin
        rst = 1'b1; pred_pc = '0; pred_opcode = '0; upd_valid = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; upd_pred = 1'b0; upd_ghr = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // T1: every index reads the weakly-not-taken reset value
        for (int i = 0; i < ENTRIES; i++) begin
            look(32'(i * 4), 7'h63);
            chk("t1_ctr", obs_ctr, 32'd1);
            chk("t1_taken", obs_taken, 32'd0);
            chk("t1_cnt", obs_cnt, 32'd0);
        end

`ifndef BHT_GSHARE_EN
        // T2: saturate up then down at pc 0x100
        for (int k = 0; k < 7; k++) begin
            upd(32'h100, 32'h100, (k < 3), 1'b0);
            chk("t2_ctr", obs_ctr, 32'(t2_exp[k]));
        end
        look(32'h100, 7'h63);
        chk("t2_floor", obs_ctr, 32'd0);

        // T3: non-branch opcode masks a strongly-taken entry
        upd(32'h104, 32'h104, 1'b1, 1'b1);
        upd(32'h104, 32'h104, 1'b1, 1'b1);
        look(32'h104, 7'h33);
        chk("t3_branch", obs_branch, 32'd0);
        chk("t3_taken", obs_taken, 32'd0);
        chk("t3_ctr", obs_ctr, 32'd0);
        look(32'h104, 7'h63);
        chk("t3_real", obs_ctr, 32'd3);

        // T4: no write bypass, alias visible next cycle
        upd(32'h40, 32'h40, 1'b1, 1'b0);
        chk("t4_same", obs_ctr, 32'd1);
        look(32'h40, 7'h63);
        chk("t4_next", obs_ctr, 32'd2);
        look(32'h140, 7'h63);
        chk("t4_alias", obs_ctr, 32'd2);
`endif

        // T5: five mispredicts, then a reset that swallows the in-flight update
        do_reset();
        for (int k = 0; k < 5; k++) begin
            upd(32'h200, 32'h200, 1'b1, 1'b0);
            chk("t5_mis", obs_mis, 32'd1);
        end
        step(1'b1, 32'h200, 7'h63, 1'b1, 32'h200, 1'b1, 1'b0, IDX_W'(gsh(m_ghr)));
        chk("t5_cnt5", obs_cnt, 32'd5);
        look(32'h200, 7'h63);
        chk("t5_cnt0", obs_cnt, 32'd0);
        chk("t5_ctr", obs_ctr, 32'd1);

        // T6: two taken updates at pc 0xC, then lookup pc 0x0
        do_reset();
        upd(32'hC, 32'hC, 1'b1, 1'b1);
        upd(32'hC, 32'hC, 1'b1, 1'b1);
        look(32'h0, 7'h63);
`ifdef BHT_GSHARE_EN
        chk("t6_ghr", obs_ghr, 32'd3);
        chk("t6_ctr", obs_ctr, 32'd2);
`else
        chk("t6_ghr", obs_ghr, 32'd0);
        chk("t6_ctr", obs_ctr, 32'd1);
`endif

        // Randomized traffic over a small PC window for frequent aliasing
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ppc, upc;
            ppc = {$urandom_range(0, 3) << 8} | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            upc = {$urandom_range(0, 3) << 8} | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            step(($urandom_range(0, 99) == 0), ppc,
                 ($urandom_range(0, 3) != 0) ? 7'h63 : 7'($urandom),
                 ($urandom_range(0, 2) != 0), upc, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0) ? IDX_W'(gsh(m_ghr)) : IDX_W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
